noise_checker: RTL
==================

# noise_checker

Self-test receiver for the PSG noise channel. It watches the generator's noise output bit one shift at a time and rebuilds the 17-bit LFSR state from the bits it sees. Once it has the state, it predicts every following bit and flags any bit that does not match. It sits beside the noise generator in test/BIST builds and has no effect on audio.

## Interface
Parameters:
- LFSR_BITS, 17, LFSR length; must match the generator.
- LFSR_TAP0, 0, first feedback tap.
- LFSR_TAP1, 3, second feedback tap.
- INVERT, 1, set to 1 when noise_in is the inverted LFSR bit 0, as the generator drives it.
- LOSS_THRESH, 4, number of consecutive mismatches that drops lock; the value 0 means lock is never dropped.
- ERR_BITS, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- sample_en  in  1  single-cycle strobe, high once per generator LFSR shift.
- noise_in  in  1  generator noise output; valid when sample_en=1.
- locked  out  1  high while a prediction is valid.
- mismatch  out  1  one-cycle pulse when a locked sample differs from its prediction.
- err_count  out  ERR_BITS  total mismatches, saturating.
- lock_lost  out  1  one-cycle pulse when locked falls.

## Operation
- Decoded bit: s = noise_in XOR INVERT.
- History register h[LFSR_BITS-1:0] holds the last 17 decoded bits; h[0] is the oldest.
  - Every sample shifts one bit in at h[16]; h[0] drops out.
- Prediction for the next bit: p = (h[LFSR_TAP0] ^ h[LFSR_TAP1]) | (h == 0). The zero term copies the generator's zero-state stuffing.
- States:
  - HUNT:
    - Each sample shifts s into h and increments fill_cnt.
    - When fill_cnt reaches LFSR_BITS (the 17th sample), go to LOCKED, set locked=1 and clear miss_run.
  - LOCKED:
    - Each sample compares s against p.
    - Match: shift s into h and clear miss_run.
    - Mismatch: pulse mismatch, increment err_count (saturating at 2^ERR_BITS-1) and increment miss_run. Shift p into h, not s (flywheel), so a single bad bit gives exactly one error.
    - If miss_run reaches LOSS_THRESH (LOSS_THRESH≠0), go to HUNT. In the same update, pulse lock_lost, set locked=0, set fill_cnt=1 and load the mismatching s into h[16] as the first sample of the new fill.
- Mismatches are counted only in LOCKED. err_count is not cleared by lock loss; only reset clears it.
- Cycles with sample_en=0 change nothing.

## Timing
- All outputs are registered and update on the clk edge that samples sample_en=1.
- locked, mismatch and lock_lost are visible the cycle after the strobe.
- Back-to-back strobes (one per clk) are supported at full rate.
- Reset: state=HUNT, h=0, fill_cnt=0, miss_run=0, locked=0, mismatch=0, lock_lost=0, err_count=0.
- reset together with sample_en: reset wins and the sample is discarded.
- Reset mid-fill or while locked: same values as above, applied on the next edge.
- fill_cnt width is $clog2(LFSR_BITS+1). miss_run width is $clog2(LOSS_THRESH+1), minimum 1, and it saturates.

## Structure
- Shared package psg_noise_pkg holds:
  - the default LFSR_BITS, LFSR_TAP0 and LFSR_TAP1 constants, also used by the generator;
  - the state enum HUNT/LOCKED.
- One combinational sub-module, noise_predict: history in, predicted bit out. It holds the tap XOR and the zero-stuff term so the generator and checker share one feedback definition.

## Test plan
- Lock from reset: reset a reference generator model and the checker, then feed 17 model bits. locked rises after the 17th strobe. Feed 2000 more bits: err_count=0, mismatch never pulses.
- Single flip: lock, then invert one noise_in bit. Exactly one mismatch pulse, err_count=1, locked stays 1, and the following 500 bits give no errors.
- Zero-stuff: INVERT=1, feed 17 samples of noise_in=1 (s=0). locked=1. Next sample noise_in=0: no mismatch. noise_in=1 instead: mismatch=1.
- Loss of lock: lock, then feed the inverted model stream. mismatch pulses on strobes 1–4, lock_lost pulses on strobe 4, locked=0, err_count=4. Resume the true stream: relock after 16 further strobes.
- Saturation: ERR_BITS=4, LOSS_THRESH=0, lock, then feed 20 inverted bits. err_count=15 and locked stays 1.
- Reset mid-operation: while locked with err_count=3, assert reset in the same cycle as sample_en. Next cycle: err_count=0, locked=0, and 17 further samples are needed to lock.

Source files
------------

// File: rtl/psg_noise_pkg.sv
// Shared PSG noise definitions: default LFSR geometry and checker state encoding.
package psg_noise_pkg;

    localparam int unsigned LFSR_BITS_DEF = 17;
    localparam int unsigned LFSR_TAP0_DEF = 0;
    localparam int unsigned LFSR_TAP1_DEF = 3;

    typedef enum logic {
        HUNT,
        LOCKED
    } chk_state_t;

endpackage

// File: rtl/noise_predict.sv
// Noise LFSR feedback: tap XOR plus the zero-state stuffing term.
module noise_predict
    import psg_noise_pkg::*;
#(
    parameter int unsigned LFSR_BITS = LFSR_BITS_DEF,
    parameter int unsigned LFSR_TAP0 = LFSR_TAP0_DEF,
    parameter int unsigned LFSR_TAP1 = LFSR_TAP1_DEF
) (
    input  logic [LFSR_BITS-1:0] hist,
    output logic                 pred
);

    always_comb begin
        pred = (hist[LFSR_TAP0] ^ hist[LFSR_TAP1]) | (hist == '0);
    end

endmodule

// File: rtl/noise_checker.sv
// Self-test receiver: rebuilds the noise LFSR from its output bits, then
// predicts each following bit and counts mismatches.
module noise_checker
    import psg_noise_pkg::*;
#(
    parameter int unsigned LFSR_BITS   = LFSR_BITS_DEF,
    parameter int unsigned LFSR_TAP0   = LFSR_TAP0_DEF,
    parameter int unsigned LFSR_TAP1   = LFSR_TAP1_DEF,
    parameter bit          INVERT      = 1'b1,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned ERR_BITS    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic                noise_in,
    output logic                locked,
    output logic                mismatch,
    output logic [ERR_BITS-1:0] err_count,
    output logic                lock_lost
);

    localparam int unsigned FW = $clog2(LFSR_BITS + 1);
    localparam int unsigned MW = (LOSS_THRESH == 0) ? 1 :
                                 (($clog2(LOSS_THRESH + 1) < 1) ? 1 : $clog2(LOSS_THRESH + 1));

    chk_state_t           state, state_n;
    logic [LFSR_BITS-1:0] hist, hist_n;
    logic [FW-1:0]        fill_cnt, fill_n;
    logic [MW-1:0]        miss_run, miss_n;
    logic                 locked_n, mismatch_n, lock_lost_n;
    logic [ERR_BITS-1:0]  err_n;
    logic                 s, pred;

    assign s = noise_in ^ INVERT;

    noise_predict #(
        .LFSR_BITS (LFSR_BITS),
        .LFSR_TAP0 (LFSR_TAP0),
        .LFSR_TAP1 (LFSR_TAP1)
    ) u_predict (
        .hist (hist),
        .pred (pred)
    );

    always_comb begin
        state_n     = state;
        hist_n      = hist;
        fill_n      = fill_cnt;
        miss_n      = miss_run;
        locked_n    = locked;
        mismatch_n  = 1'b0;
        lock_lost_n = 1'b0;
        err_n       = err_count;
        if (sample_en) begin
            case (state)
                HUNT: begin
                    hist_n = {s, hist[LFSR_BITS-1:1]};
                    fill_n = fill_cnt + 1'b1;
                    if (fill_cnt == FW'(LFSR_BITS - 1)) begin
                        state_n  = LOCKED;
                        locked_n = 1'b1;
                        miss_n   = '0;
                    end
                end
                LOCKED: begin
                    if (s == pred) begin
                        hist_n = {s, hist[LFSR_BITS-1:1]};
                        miss_n = '0;
                    end else begin
                        mismatch_n = 1'b1;
                        if (err_count != '1) err_n = err_count + 1'b1;
                        if (miss_run != '1) miss_n = miss_run + 1'b1;
                        // Flywheel: keep the predicted bit so one bad sample costs one error.
                        hist_n = {pred, hist[LFSR_BITS-1:1]};
                        if ((LOSS_THRESH != 0) &&
                            ((32'(miss_run) + 32'd1) >= 32'(LOSS_THRESH))) begin
                            state_n     = HUNT;
                            lock_lost_n = 1'b1;
                            locked_n    = 1'b0;
                            fill_n      = FW'(1);
                            miss_n      = '0;
                            hist_n      = {s, hist[LFSR_BITS-1:1]};
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            hist      <= '0;
            fill_cnt  <= '0;
            miss_run  <= '0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
            lock_lost <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            fill_cnt  <= fill_n;
            miss_run  <= miss_n;
            locked    <= locked_n;
            mismatch  <= mismatch_n;
            lock_lost <= lock_lost_n;
            err_count <= err_n;
        end
    end

endmodule
